// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C request arbiter and related blocks.
//
// Contents:
//   I2cAddrWidth - width of a 7-bit I2C slave address
//   St*Enc       - 3-bit state encodings of the arbiter controller
//   arb_state_e  - typed FSM state built on those encodings
package i2c_pkg;

  localparam int unsigned I2cAddrWidth = 7;
  localparam int unsigned I2cDataWidth = 8;

  localparam logic [2:0] StIdleEnc     = 3'd0;
  localparam logic [2:0] StIssueEnc    = 3'd1;
  localparam logic [2:0] StWaitBusyEnc = 3'd2;
  localparam logic [2:0] StWaitDoneEnc = 3'd3;
  localparam logic [2:0] StCompleteEnc = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = StIdleEnc,
    StIssue    = StIssueEnc,
    StWaitBusy = StWaitBusyEnc,
    StWaitDone = StWaitDoneEnc,
    StComplete = StCompleteEnc
  } arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker.
//
// Searches i_req starting at index i_ptr and wrapping modulo N; the first set
// bit wins.
//
// Ports:
//   i_req   [N-1:0]    request vector
//   i_ptr   [IdxW-1:0] index with highest priority this round
//   o_grant [N-1:0]    one-hot winner, zero when no request
//   o_idx   [IdxW-1:0] binary index of the winner, zero when no request
//   o_valid            at least one request present
module rr_priority_select #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [IdxW-1:0] o_idx,
  output logic            o_valid
);

  logic [IdxW-1:0] scan_idx;

  always_comb begin
    o_grant  = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = IdxW'((32'(i_ptr) + i) % N);
      if (!o_valid && i_req[scan_idx]) begin
        o_valid           = 1'b1;
        o_idx             = scan_idx;
        o_grant[scan_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_request_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C master engine among
// NUM_REQ requesters. The winner's address, byte and direction are latched,
// one start pulse is issued, the engine's busy flag is tracked to completion
// and a one-cycle done (plus error) pulse is returned to the owner.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req            per-requester level request, held until its o_done
//   i_req_rnw        per-requester direction (1 = read)
//   i_req_addr       packed 7-bit slave addresses, requester k at [7k+6:7k]
//   i_req_byte       packed write bytes, requester k at [8k+7:8k]
//   o_grant          one-hot current owner, zero when idle
//   o_done           one-hot single-cycle completion pulse
//   o_error          failure flag, coincident with o_done
//   o_rd_byte        read data, valid with o_done of a read
//   o_m_*            command outputs to the engine
//   i_m_*            status inputs from the engine
module i2c_request_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_REQ-1:0]                i_req,
  input  logic [NUM_REQ-1:0]                i_req_rnw,
  input  logic [I2cAddrWidth*NUM_REQ-1:0]   i_req_addr,
  input  logic [I2cDataWidth*NUM_REQ-1:0]   i_req_byte,
  output logic [NUM_REQ-1:0]                o_grant,
  output logic [NUM_REQ-1:0]                o_done,
  output logic                              o_error,
  output logic [I2cDataWidth-1:0]           o_rd_byte,
  output logic [I2cAddrWidth-1:0]           o_m_slave_addr,
  output logic [I2cDataWidth-1:0]           o_m_wr_byte,
  output logic                              o_m_wr_start,
  output logic                              o_m_rd_start,
  input  logic                              i_m_busy,
  input  logic [I2cDataWidth-1:0]           i_m_rd_byte,
  input  logic                              i_m_error
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [IdxW-1:0]         ptr_q, ptr_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [I2cAddrWidth-1:0] addr_q, addr_d;
  logic [I2cDataWidth-1:0] byte_q, byte_d;
  logic                    rnw_q, rnw_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [I2cDataWidth-1:0] rd_byte_q, rd_byte_d;

  logic [NUM_REQ-1:0]      sel_grant;
  logic [IdxW-1:0]         sel_idx;
  logic                    sel_valid;

  rr_priority_select #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_select (
    .i_req   (i_req),
    .i_ptr   (ptr_q),
    .o_grant (sel_grant),
    .o_idx   (sel_idx),
    .o_valid (sel_valid)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    byte_d    = byte_q;
    rnw_d     = rnw_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_byte_d = rd_byte_q;

    unique case (state_q)
      StIdle: begin
        // Request payload is only looked at here; later changes are ignored.
        if (sel_valid) begin
          grant_d = sel_grant;
          idx_d   = sel_idx;
          addr_d  = i_req_addr[sel_idx*I2cAddrWidth +: I2cAddrWidth];
          byte_d  = i_req_byte[sel_idx*I2cDataWidth +: I2cDataWidth];
          rnw_d   = i_req_rnw[sel_idx];
          state_d = StIssue;
        end
      end

      StIssue: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = StWaitBusy;
      end

      StWaitBusy: begin
        if (i_m_error) begin
          err_d = 1'b1;
        end
        if (i_m_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntLast) begin
          // Engine never acknowledged the start.
          err_d   = 1'b1;
          state_d = StComplete;
          if (rnw_q) begin
            rd_byte_d = i_m_rd_byte;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StWaitDone: begin
        if (i_m_error) begin
          err_d = 1'b1;
        end
        if (!i_m_busy) begin
          state_d = StComplete;
          if (rnw_q) begin
            rd_byte_d = i_m_rd_byte;
          end
        end
      end

      StComplete: begin
        // Owner just served drops to lowest priority next round.
        ptr_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        grant_d = '0;
        state_d = StIdle;
      end

      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      byte_q    <= '0;
      rnw_q     <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rd_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      byte_q    <= byte_d;
      rnw_q     <= rnw_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rd_byte_q <= rd_byte_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign o_grant        = grant_q;
  assign o_done         = (state_q == StComplete) ? grant_q : '0;
  assign o_error        = (state_q == StComplete) && err_q;
  assign o_rd_byte      = rd_byte_q;
  assign o_m_slave_addr = addr_q;
  assign o_m_wr_byte    = byte_q;
  assign o_m_wr_start   = (state_q == StIssue) && !rnw_q;
  assign o_m_rd_start   = (state_q == StIssue) && rnw_q;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Self-checking bench for i2c_request_arbiter with a behavioural engine model
// and a scoreboard of expected transactions in grant order.
module tb_i2c_request_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned TMO = 16;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [NR-1:0]   i_req;
  logic [NR-1:0]   i_req_rnw;
  logic [7*NR-1:0] i_req_addr;
  logic [8*NR-1:0] i_req_byte;
  logic [NR-1:0]   o_grant;
  logic [NR-1:0]   o_done;
  logic            o_error;
  logic [7:0]      o_rd_byte;
  logic [6:0]      o_m_slave_addr;
  logic [7:0]      o_m_wr_byte;
  logic            o_m_wr_start;
  logic            o_m_rd_start;
  logic            i_m_busy;
  logic [7:0]      i_m_rd_byte;
  logic            i_m_error;

  i2c_request_arbiter #(
    .NUM_REQ     (NR),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_req          (i_req),
    .i_req_rnw      (i_req_rnw),
    .i_req_addr     (i_req_addr),
    .i_req_byte     (i_req_byte),
    .o_grant        (o_grant),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_rd_byte      (o_rd_byte),
    .o_m_slave_addr (o_m_slave_addr),
    .o_m_wr_byte    (o_m_wr_byte),
    .o_m_wr_start   (o_m_wr_start),
    .o_m_rd_start   (o_m_rd_start),
    .i_m_busy       (i_m_busy),
    .i_m_rd_byte    (i_m_rd_byte),
    .i_m_error      (i_m_error)
  );

  always #5 i_clk = ~i_clk;

  // Engine model: busy rises the cycle after a start and stays high eng_len cycles.
  logic       eng_no_busy;
  logic       eng_err;
  logic [7:0] eng_rd_data;
  int         eng_len;
  int         busy_cnt;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i_m_busy    <= 1'b0;
      i_m_error   <= 1'b0;
      i_m_rd_byte <= 8'h00;
      busy_cnt    <= 0;
    end else begin
      i_m_error <= 1'b0;
      if ((o_m_wr_start || o_m_rd_start) && !eng_no_busy) begin
        i_m_busy <= 1'b1;
        busy_cnt <= eng_len;
        if (o_m_rd_start) i_m_rd_byte <= eng_rd_data;
      end else if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) i_m_busy <= 1'b0;
        if (busy_cnt == 2 && eng_err) i_m_error <= 1'b1;
      end
    end
  end

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic [7:0] wbyte;
    logic       rnw;
    logic [7:0] rd;
    logic       err;
    logic       tmo;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         start_cyc, fall_cyc, start_cnt;
  logic       prev_busy, after_done;
  logic [7:0] last_rd;
  int         budget[NR];
  int         served[NR];
  logic [6:0] m_addr[NR];
  logic [7:0] m_byte[NR];
  logic       m_rnw[NR];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  task automatic update_req();
    for (int k = 0; k < NR; k++) i_req[k] = (budget[k] > served[k]);
  endtask

  task automatic set_req(input int k, input logic [6:0] a, input logic [7:0] b, input logic r);
    m_addr[k] = a;
    m_byte[k] = b;
    m_rnw[k]  = r;
    i_req_addr[k*7 +: 7] = a;
    i_req_byte[k*8 +: 8] = b;
    i_req_rnw[k]         = r;
  endtask

  task automatic push(input int k, input logic [7:0] rd, input logic err, input logic tmo);
    exp_t e;
    e.idx   = k;
    e.addr  = m_addr[k];
    e.wbyte = m_byte[k];
    e.rnw   = m_rnw[k];
    e.rd    = rd;
    e.err   = err;
    e.tmo   = tmo;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (!i_rst_n) begin
      start_cnt  = 0;
      last_rd    = 8'h00;
      prev_busy  = 1'b0;
      after_done = 1'b0;
      return;
    end
    if (after_done) begin
      check("grant_clr", o_grant, 0);
      after_done = 1'b0;
    end
    if (prev_busy && !i_m_busy) fall_cyc = cyc;
    prev_busy = i_m_busy;
    if (o_m_wr_start || o_m_rd_start) begin
      start_cnt++;
      start_cyc = cyc;
      if (sb.size() == 0) begin
        check("start_unexp", {o_m_rd_start, o_m_wr_start}, 0);
      end else begin
        e = sb[0];
        check("start_grant", o_grant, 1 << e.idx);
        check("start_dir", {o_m_rd_start, o_m_wr_start}, e.rnw ? 2'b10 : 2'b01);
        check("start_addr", o_m_slave_addr, e.addr);
        check("start_byte", o_m_wr_byte, e.wbyte);
      end
    end
    if (o_done != '0) begin
      if (sb.size() == 0) begin
        check("done_unexp", o_done, 0);
      end else begin
        e = sb.pop_front();
        check("done_onehot", o_done, 1 << e.idx);
        check("done_err", o_error, e.err);
        check("start_once", start_cnt, 1);
        if (e.rnw) last_rd = e.rd;
        check("rd_byte", o_rd_byte, last_rd);
        if (e.tmo) check("tmo_lat", cyc - start_cyc, TMO + 1);
        else check("busy_to_done", cyc - fall_cyc, 1);
        served[e.idx]++;
      end
      start_cnt  = 0;
      after_done = 1'b1;
    end else if (o_error) begin
      check("error_alone", o_error, 0);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    cyc++;
    monitor();
    update_req();
  endtask

  task automatic wait_drain(input string tag, input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      tick();
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, o_grant, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_error"}, o_error, 0);
    check({tag, "_starts"}, {o_m_rd_start, o_m_wr_start}, 0);
    check({tag, "_addr"}, o_m_slave_addr, 0);
  endtask

  initial begin
    int base;
    int n;
    i_rst_n     = 1'b0;
    i_req       = '0;
    i_req_rnw   = '0;
    i_req_addr  = '0;
    i_req_byte  = '0;
    eng_no_busy = 1'b0;
    eng_err     = 1'b0;
    eng_len     = 3;
    eng_rd_data = 8'h00;
    start_cnt   = 0;
    start_cyc   = 0;
    fall_cyc    = 0;
    prev_busy   = 1'b0;
    after_done  = 1'b0;
    last_rd     = 8'h00;
    for (int k = 0; k < NR; k++) begin
      budget[k] = 0;
      served[k] = 0;
      m_addr[k] = '0;
      m_byte[k] = '0;
      m_rnw[k]  = 1'b0;
    end

    repeat (3) tick();
    check_all_zero("rst");
    check("rst_rd_byte", o_rd_byte, 0);
    i_rst_n = 1'b1;
    tick();

    // Single write from requester 0, grant one cycle after sampling.
    set_req(0, 7'h48, 8'hA5, 1'b0);
    push(0, 8'h00, 1'b0, 1'b0);
    budget[0] = served[0] + 1;
    update_req();
    check("grant_pre", o_grant, 0);
    tick();
    check("grant_lat", o_grant, 4'b0001);
    wait_drain("drain_single", 100);

    // Contention from reset: two full rounds 0,1,2,3,0,1,2,3.
    tick();
    i_rst_n = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    for (int k = 0; k < NR; k++) begin
      set_req(k, 7'(8'h10 + k), 8'(8'h20 + k), 1'b0);
      budget[k] = served[k] + 2;
    end
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NR; k++) push(k, 8'h00, 1'b0, 1'b0);
    update_req();
    wait_drain("drain_contention", 400);

    // Fairness: 1 and 3 alternate, then 0 joins and is served next.
    set_req(1, 7'h21, 8'h31, 1'b0);
    set_req(3, 7'h23, 8'h33, 1'b0);
    set_req(0, 7'h20, 8'h30, 1'b0);
    budget[1] = served[1] + 3;
    budget[3] = served[3] + 3;
    push(1, 8'h00, 1'b0, 1'b0);
    push(3, 8'h00, 1'b0, 1'b0);
    update_req();
    base = served[1] + served[3];
    n = 0;
    while ((served[1] + served[3]) - base < 2 && n < 200) begin
      tick();
      n++;
    end
    check("fair_phase1", (served[1] + served[3]) - base, 2);
    push(0, 8'h00, 1'b0, 1'b0);
    push(1, 8'h00, 1'b0, 1'b0);
    push(3, 8'h00, 1'b0, 1'b0);
    push(1, 8'h00, 1'b0, 1'b0);
    push(3, 8'h00, 1'b0, 1'b0);
    budget[0] = served[0] + 1;
    update_req();
    wait_drain("drain_fair", 400);

    // Read from requester 2.
    eng_rd_data = 8'h3C;
    set_req(2, 7'h2C, 8'h00, 1'b1);
    push(2, 8'h3C, 1'b0, 1'b0);
    budget[2] = served[2] + 1;
    update_req();
    wait_drain("drain_read", 100);

    // Engine error during a write from requester 1.
    eng_err = 1'b1;
    set_req(1, 7'h51, 8'h5A, 1'b0);
    push(1, 8'h00, 1'b1, 1'b0);
    budget[1] = served[1] + 1;
    update_req();
    wait_drain("drain_err", 100);
    eng_err = 1'b0;

    // Timeout: engine never raises busy.
    eng_no_busy = 1'b1;
    set_req(3, 7'h33, 8'hC3, 1'b0);
    push(3, 8'h00, 1'b1, 1'b1);
    budget[3] = served[3] + 1;
    update_req();
    wait_drain("drain_tmo", 100);
    eng_no_busy = 1'b0;

    // Normal service after a timeout.
    set_req(0, 7'h48, 8'h11, 1'b0);
    push(0, 8'h00, 1'b0, 1'b0);
    budget[0] = served[0] + 1;
    update_req();
    wait_drain("drain_recover", 100);

    // Reset while waiting for the engine to finish.
    eng_len = 10;
    set_req(1, 7'h61, 8'h77, 1'b0);
    push(1, 8'h00, 1'b0, 1'b0);
    budget[1] = served[1] + 1;
    update_req();
    n = 0;
    while (!i_m_busy && n < 20) begin
      tick();
      n++;
    end
    check("busy_seen", i_m_busy, 1);
    repeat (2) tick();
    i_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    sb.delete();
    budget[1] = served[1];
    update_req();
    tick();
    i_rst_n = 1'b1;
    eng_len = 3;
    repeat (5) tick();

    // Pointer back at 0: requester 0 wins over 2.
    set_req(0, 7'h40, 8'h01, 1'b0);
    set_req(2, 7'h42, 8'h02, 1'b0);
    push(0, 8'h00, 1'b0, 1'b0);
    push(2, 8'h00, 1'b0, 1'b0);
    budget[0] = served[0] + 1;
    budget[2] = served[2] + 1;
    update_req();
    wait_drain("drain_post_rst", 200);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_request_arbiter.md
Name: i2c_request_arbiter

Overview:
- Round-robin arbiter that shares one i2c_master_single_byte engine among NUM_REQ independent requesters (sensor pollers, config loaders, debug port).
- Latches the winning requester's slave address, data byte and direction, then issues one start pulse to the engine.
- Tracks the engine's o_busy until the transaction completes and returns a per-requester done/error pulse.
- Sits between the application blocks and the I2C engine; it is the only driver of the engine's command inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 1024, cycles to wait for engine busy to rise after a start pulse before flagging an error (must be > 2)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  NUM_REQ  per-requester request, level; held until that requester's o_done
- i_req_rnw  in  NUM_REQ  per-requester direction: 1 = read, 0 = write
- i_req_addr  in  7*NUM_REQ  packed slave addresses; requester k uses bits [7k+6:7k]
- i_req_byte  in  8*NUM_REQ  packed write bytes; requester k uses bits [8k+7:8k]
- o_grant  out  NUM_REQ  one-hot owner of the engine; all zero when idle
- o_done  out  NUM_REQ  one-hot, single-cycle completion pulse to the owner
- o_error  out  1  single-cycle pulse, coincident with o_done, when the transaction failed
- o_rd_byte  out  8  read data, valid in the o_done cycle for read transactions
- o_m_slave_addr  out  7  to engine i_slave_addr
- o_m_wr_byte  out  8  to engine i_wr_byte
- o_m_wr_start  out  1  to engine i_wr_start, single-cycle pulse
- o_m_rd_start  out  1  to engine i_rd_start, single-cycle pulse
- i_m_busy  in  1  from engine o_busy
- i_m_rd_byte  in  8  from engine o_rd_byte
- i_m_error  in  1  from engine o_error

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; round-robin pointer = 0, so requester 0 has top priority. Reset mid-transaction abandons it with no o_done; the engine has its own reset.
- IDLE:
  - If any i_req bit is set, select the first set bit searching from pointer, pointer+1, ... modulo NUM_REQ.
  - Register that requester's addr/byte/rnw into o_m_slave_addr/o_m_wr_byte and an internal rnw latch.
  - Set o_grant one-hot and go to ISSUE.
  - Arbitration takes one cycle, so the grant appears the cycle after the request is sampled.
- ISSUE (1 cycle): pulse o_m_wr_start (rnw=0) or o_m_rd_start (rnw=1) for exactly one cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - On i_m_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC-1, go to COMPLETE with the error flag set.
- WAIT_DONE:
  - On i_m_busy=0, go to COMPLETE.
  - The error flag is set if i_m_error was seen high during WAIT_BUSY or WAIT_DONE (sticky).
- COMPLETE (1 cycle):
  - o_done = o_grant, o_error = error flag.
  - o_rd_byte = i_m_rd_byte, captured for read transactions; otherwise o_rd_byte holds its previous value.
  - pointer = granted index + 1 mod NUM_REQ.
  - Go to IDLE; o_grant clears on that transition.
- Engine inputs (addr/byte) stay stable from ISSUE through COMPLETE.
- i_req, addr, byte and rnw are sampled only in IDLE. Changes during a transaction are ignored. Dropping i_req mid-transaction still produces o_done to that index.
- Requester held high after o_done: it re-enters arbitration in IDLE, now at lowest priority relative to its own last grant.
- Simultaneous requests: strict round-robin. No requester waits more than NUM_REQ-1 transactions.
- Minimum back-to-back spacing: IDLE→ISSUE→WAIT_BUSY→...→COMPLETE→IDLE, so at least 1 idle cycle between transactions.
- Counter width is clog2(TIMEOUT_CYC) and never wraps, because it is cleared in ISSUE.

Decomposition:
- Shared package i2c_pkg: state encoding (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE as 3-bit localparams) and the I2C address width constant (7).
- One natural sub-module, rr_priority_select: combinational round-robin picker (inputs req vector and pointer; outputs one-hot grant, index, valid). Reusable by other shared-resource arbiters.

Test Plan:
- Single write: req[0], addr 0x48, byte 0xA5, rnw=0 → grant 0001 one cycle later; o_m_wr_start pulses once with o_m_slave_addr=0x48 and o_m_wr_byte=0xA5; o_done=0001 one cycle after busy falls; o_error=0.
- Contention: req=1111 held for 4 transactions starting from reset → grants 0001, 0010, 0100, 1000 in order; pointer then wraps to 0.
- Fairness: req[1] and req[3] held continuously, req[0] asserted mid-run → req[0] served within 2 transactions; grants alternate 1, 3 before req[0] joins.
- Read: req[2], rnw=1, model returns 0x3C → o_m_rd_start pulses (not wr_start); o_rd_byte=0x3C in the o_done=0100 cycle.
- Timeout: busy held low after start, TIMEOUT_CYC=16 → o_done and o_error both pulse 16 cycles after WAIT_BUSY entry; the next request is served normally.
- Reset mid-WAIT_DONE: i_rst_n low for 1 cycle → grant/done/error/start all 0 immediately; no o_done; pointer back to 0, so req[0] wins next.
